// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with byte enables and a sequenced clear engine.
// Optional write-through bypass on both read ports: define REG_FILE_2R1W_BYPASS_EN.

module reg_file_2r1w_lane #(
    parameter int W = 8
) (
    input  logic [W-1:0] old_b,
    input  logic [W-1:0] new_b,
    input  logic         en,
    output logic [W-1:0] out_b
);
    assign out_b = en ? new_b : old_b;
endmodule

module reg_file_2r1w #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH/8-1:0] w_be,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [ADDR_WIDTH-1:0]   r_addr_a,
    input  logic [ADDR_WIDTH-1:0]   r_addr_b,
    output logic [DATA_WIDTH-1:0]   r_data_a,
    output logic [DATA_WIDTH-1:0]   r_data_b,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} state_t;

    state_t                               state, state_nxt;
    logic [ADDR_WIDTH-1:0]                idx, idx_nxt;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem;
    logic [DATA_WIDTH-1:0]                wr_old, wr_word;
    logic                                 wr_acc;

    // Writes are only honoured while the clear engine is idle.
    assign wr_acc = wr_en && (state == IDLE);
    assign wr_old = mem[w_addr];

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            reg_file_2r1w_lane #(.W(8)) u_lane (
                .old_b (wr_old[8*g +: 8]),
                .new_b (w_data[8*g +: 8]),
                .en    (w_be[g]),
                .out_b (wr_word[8*g +: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                // Stop on the last entry instead of letting the index wrap.
                if (idx == LAST_IDX) state_nxt = DONE;
                else                 idx_nxt   = idx + 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state)
            CLEAR:   clr_busy = 1'b1;
            DONE:    clr_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             mem         <= {DEPTH{RESET_VALUE}};
        else if (state == CLEAR)  mem[idx]    <= RESET_VALUE;
        else if (wr_acc)          mem[w_addr] <= wr_word;
    end

`ifdef REG_FILE_2R1W_BYPASS_EN
    // Forward only accepted writes; clear writes are never forwarded.
    assign r_data_a = (wr_acc && (r_addr_a == w_addr)) ? wr_word : mem[r_addr_a];
    assign r_data_b = (wr_acc && (r_addr_b == w_addr)) ? wr_word : mem[r_addr_b];
`else
    assign r_data_a = mem[r_addr_a];
    assign r_data_b = mem[r_addr_b];
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w; stimulus queues expectations, a monitor compares on each check strobe.
module tb_reg_file_2r1w;
`ifdef REG_FILE_2R1W_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  w_addr = '0;
    logic [1:0]  w_be = '0;
    logic [15:0] w_data = '0;
    logic [1:0]  r_addr_a = '0;
    logic [1:0]  r_addr_b = '0;
    logic [15:0] r_data_a, r_data_b;
    logic        clr_req = 1'b0;
    logic        clr_busy, clr_done;

    reg_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .RESET_VALUE(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .w_addr(w_addr), .w_be(w_be),
        .w_data(w_data), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
        .r_data_a(r_data_a), .r_data_b(r_data_b), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #50 clk = ~clk;

    int dcnt = 0;
    always @(negedge clk) if (clr_done === 1'b1) dcnt++;

    // Scoreboard: kind 0=r_data_a 1=r_data_b 2=clr_busy 3=clr_done 4=done-pulse count
    string       qn[$];
    int          qk[$];
    logic [15:0] qe[$];
    event        chk_ev;
    int          n_cmp = 0, n_err = 0;

    always begin
        string       n;
        int          k;
        logic [15:0] e, a;
        @(chk_ev);
        while (qk.size() > 0) begin
            n = qn.pop_front();
            k = qk.pop_front();
            e = qe.pop_front();
            case (k)
                0:       a = r_data_a;
                1:       a = r_data_b;
                2:       a = {15'd0, clr_busy};
                3:       a = {15'd0, clr_done};
                default: a = 16'(dcnt);
            endcase
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s (kind %0d): got %h, want %h", n, k, a, e);
            end
        end
    end

    task automatic push_exp(input string n, input int k, input logic [15:0] v);
        qn.push_back(n); qk.push_back(k); qe.push_back(v);
    endtask

    task automatic fire();
        #1; -> chk_ev; #1;
    endtask

    task automatic rd2(input string n, input logic [1:0] a, input logic [1:0] b,
                       input logic [15:0] ea, input logic [15:0] eb);
        r_addr_a = a; r_addr_b = b;
        push_exp(n, 0, ea); push_exp(n, 1, eb);
        fire();
    endtask

    task automatic stat(input string n, input logic busy, input logic done);
        push_exp(n, 2, {15'd0, busy}); push_exp(n, 3, {15'd0, done});
        fire();
    endtask

    task automatic dchk(input string n, input int v);
        push_exp(n, 4, 16'(v));
        fire();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        wr_en = 1'b1; w_addr = a; w_data = d; w_be = be;
        @(negedge clk);
        wr_en = 1'b0; w_be = 2'b00;
    endtask

    task automatic fill();
        for (int i = 0; i < 4; i++) wr(2'(i), 16'(i + 1), 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #20 reset_n = 1'b0;
        rd2("rst_e01", 2'd0, 2'd1, 16'h0000, 16'h0000);
        rd2("rst_e23", 2'd2, 2'd3, 16'h0000, 16'h0000);
        rd2("rst_e10", 2'd1, 2'd0, 16'h0000, 16'h0000);
        rd2("rst_e32", 2'd3, 2'd2, 16'h0000, 16'h0000);
        stat("rst_stat", 1'b0, 1'b0);
        #5 reset_n = 1'b1;

        // Byte enables, including an all-zero mask.
        wr(2'd1, 16'hABCD, 2'b11);
        wr(2'd1, 16'h1234, 2'b01);
        rd2("be_lo", 2'd1, 2'd1, 16'hAB34, 16'hAB34);
        wr(2'd1, 16'hFFFF, 2'b00);
        rd2("be_none", 2'd1, 2'd0, 16'hAB34, 16'h0000);

        // Bypass behaviour in the write cycle, and stored value after the edge.
        wr(2'd2, 16'h5555, 2'b11);
        @(negedge clk);
        wr_en = 1'b1; w_addr = 2'd2; w_data = 16'hFFFF; w_be = 2'b10;
        rd2("byp_same", 2'd2, 2'd0, BYP ? 16'hFF55 : 16'h5555, 16'h0000);
        @(negedge clk);
        wr_en = 1'b0; w_be = 2'b00;
        rd2("byp_after", 2'd2, 2'd2, 16'hFF55, 16'hFF55);

        // Basic clear sequence.
        fill();
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
        stat("clr_c0", 1'b1, 1'b0); rd2("clr_c0", 2'd0, 2'd3, 16'h0001, 16'h0004);
        @(negedge clk);
        stat("clr_c1", 1'b1, 1'b0); rd2("clr_c1", 2'd0, 2'd3, 16'h0000, 16'h0004);
        @(negedge clk);
        stat("clr_c2", 1'b1, 1'b0); rd2("clr_c2", 2'd1, 2'd2, 16'h0000, 16'h0003);
        @(negedge clk);
        stat("clr_c3", 1'b1, 1'b0); rd2("clr_c3", 2'd2, 2'd3, 16'h0000, 16'h0004);
        @(negedge clk);
        stat("clr_done", 1'b0, 1'b1);
        @(negedge clk);
        stat("clr_idle", 1'b0, 1'b0); dchk("clr_dcnt", 1);
        rd2("clr_all01", 2'd0, 2'd1, 16'h0000, 16'h0000);
        rd2("clr_all23", 2'd2, 2'd3, 16'h0000, 16'h0000);

        // Write and repeated clr_req while the clear is running or finishing.
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; w_addr = 2'd0; w_data = 16'h7777; w_be = 2'b11;
        rd2("intf_nobyp", 2'd0, 2'd1, 16'h0000, 16'h0000);
        @(negedge clk); wr_en = 1'b0; w_be = 2'b00; clr_req = 1'b0;
        @(negedge clk);
        @(negedge clk); stat("intf_done", 1'b0, 1'b1); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0; stat("intf_idle", 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        stat("intf_quiet", 1'b0, 1'b0); dchk("intf_dcnt", 2);
        rd2("intf_e0", 2'd0, 2'd0, 16'h0000, 16'h0000);

        // Write and clr_req together in IDLE: write lands first.
        @(negedge clk);
        wr_en = 1'b1; w_addr = 2'd2; w_data = 16'h2222; w_be = 2'b11; clr_req = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; w_be = 2'b00; clr_req = 1'b0;
        stat("both_c0", 1'b1, 1'b0); rd2("both_c0", 2'd2, 2'd0, 16'h2222, 16'h0000);
        repeat (5) @(negedge clk);
        dchk("both_dcnt", 3); rd2("both_e2", 2'd2, 2'd3, 16'h0000, 16'h0000);

        // Reset in the middle of a clear aborts it.
        fill();
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        stat("abort_stat", 1'b0, 1'b0);
        rd2("abort_e01", 2'd0, 2'd1, 16'h0000, 16'h0000);
        rd2("abort_e23", 2'd2, 2'd3, 16'h0000, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        wr_en = 1'b1; w_addr = 2'd3; w_data = 16'hBEEF; w_be = 2'b11;
        @(negedge clk);
        wr_en = 1'b0; w_be = 2'b00;
        rd2("post_rst_wr", 2'd3, 2'd3, 16'hBEEF, 16'hBEEF);
        repeat (4) @(negedge clk);
        stat("abort_quiet", 1'b0, 1'b0); dchk("abort_dcnt", 3);

        repeat (5) if (qk.size() > 0) #1;
        if (qk.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d checks pending, want 0", qk.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, word width in bits; legal values are multiples of 8, at least 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, address bits; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, DATA_WIDTH-wide value loaded by reset and by clear.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port wr_en, input, 1, write request.
REQ-007 The block SHALL have port w_addr, input, ADDR_WIDTH, write address.
REQ-008 The block SHALL have port w_be, input, DATA_WIDTH/8, byte enables; bit k selects bits [8k+7:8k].
REQ-009 The block SHALL have port w_data, input, DATA_WIDTH, write data.
REQ-010 The block SHALL have ports r_addr_a and r_addr_b, input, ADDR_WIDTH each, read addresses for ports A and B.
REQ-011 The block SHALL have ports r_data_a and r_data_b, output, DATA_WIDTH each, read data for ports A and B.
REQ-012 The block SHALL have port clr_req, input, 1, request to clear all entries.
REQ-013 The block SHALL have port clr_busy, output, 1, high while a clear is in progress.
REQ-014 The block SHALL have port clr_done, output, 1, one-cycle pulse when a clear completes.

Function
REQ-015 Reads SHALL be combinational on both ports, independent of each other; both ports MAY address the same entry.
REQ-016 An accepted write SHALL update only the bytes of entry w_addr whose w_be bit is 1; other bytes hold.
REQ-017 A write SHALL be accepted when wr_en=1 and the state is IDLE; with w_be all zero it SHALL change nothing.
REQ-018 Without bypass, written data SHALL be visible on a read port from the cycle after the write edge.
REQ-019 The clear sequencer SHALL have states IDLE, CLEAR and DONE.
REQ-020 In IDLE, clr_req=1 at a rising edge SHALL move the state to CLEAR with index counter 0.
REQ-021 In CLEAR, each edge SHALL write RESET_VALUE to entry index and increment index; at index DEPTH-1 the state SHALL go to DONE; CLEAR lasts exactly DEPTH cycles.
REQ-022 In DONE, the state SHALL return to IDLE on the next edge.
REQ-023 clr_busy SHALL be 1 exactly in CLEAR; clr_done SHALL be 1 exactly in DONE.
REQ-024 clr_req in CLEAR or DONE SHALL be ignored, not queued.
REQ-025 wr_en in CLEAR or DONE SHALL be dropped with no effect on the array.
REQ-026 Reads during CLEAR SHALL return current contents: already-cleared entries read RESET_VALUE, the rest hold old data.
REQ-027 wr_en and clr_req together in IDLE SHALL perform the write on that edge, then start the clear.
REQ-028 The index counter SHALL be ADDR_WIDTH bits and SHALL NOT wrap during a clear.

Reset
REQ-029 reset_n=0 SHALL immediately set every entry to RESET_VALUE, state to IDLE, index to 0, and clr_busy and clr_done to 0.
REQ-030 reset_n asserted during CLEAR SHALL abort the clear; no clr_done pulse follows.
REQ-031 After reset_n deasserts, the block SHALL accept writes and clr_req from the first rising edge.

Configuration
REQ-032 Macro REG_FILE_2R1W_BYPASS_EN SHALL select write-through bypass.
REQ-033 With the macro defined, when a write is accepted and r_addr_x equals w_addr, r_data_x SHALL combinationally show the stored word merged with w_data under w_be in the same cycle.
REQ-034 With the macro undefined, r_data_x SHALL always show stored contents only, per REQ-018.
REQ-035 Clear writes SHALL never be bypassed in either configuration.

Verification (DATA_WIDTH=16, ADDR_WIDTH=2, RESET_VALUE=0)
REQ-036 Reset: hold reset_n=0 mid-cycle -> all four entries read 16'h0000 on both ports with no clock edge; clr_busy=0 and clr_done=0.
REQ-037 Byte enable: write 16'hABCD to entry 1, then write 16'h1234 with w_be=2'b01 -> entry 1 reads 16'hAB34 on ports A and B.
REQ-038 Bypass: entry 2=16'h5555; write 16'hFFFF with w_be=2'b10 and r_addr_a=2 -> 16'hFF55 in the same cycle when defined; 16'h5555 until the edge when undefined.
REQ-039 Clear: fill the entries with 1..4 and pulse clr_req -> clr_busy high for 4 cycles; entry 0 reads 0 after the first clear edge while entry 3 still reads 4; one clr_done pulse; all entries 0.
REQ-040 Clear interference: wr_en to entry 0 with 16'h7777 and a second clr_req during CLEAR -> the write is lost, only one clr_done occurs, entry 0 reads 0.
REQ-041 Abort: assert reset_n=0 at clear cycle 2 -> immediate IDLE, clr_busy=0, all entries 0, and no clr_done pulse.
